bob_indir_mp: RTL

- Multi-port successor to the single-port BOB indirection store.
- Holds ADDR_COUNT entries of DATA_WIDTH payload, each with a resettable per-entry ready bit.
- Each of RD_PORTS read ports runs a small FSM. A port holds its captured address until the entry is ready, then delivers one valid beat.
- Sits between the BOB writeback paths and the consumers that replay or retire BOB results.

---
 rtl/bob_indir_mp.sv | 86 ++++++++
 1 files changed

// File: rtl/bob_indir_mp.sv
// Multi-port BOB indirection store: payload array plus per-entry ready bitmap.
// Each read port holds its captured index until that entry is ready, then delivers one beat.
module bob_indir_mp #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 65,
  parameter int ADDR_COUNT = 16,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RD_PORTS-1:0]            rd_clkEn,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_valid,
  output logic [RD_PORTS-1:0]            rd_wait,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [WR_PORTS-1:0]            wr_wen,
  input  logic [ADDR_WIDTH-1:0]          rdyI_addr,
  input  logic                           rdyI_ready,
  input  logic                           rdyI_wen,
  input  logic                           flush
);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [DATA_WIDTH-1:0] ram [ADDR_COUNT];
  logic [ADDR_COUNT-1:0] ready;

  // Later loop iterations override earlier ones, so the highest write port wins a collision.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WR_PORTS; w++) begin
      if (wr_wen[w]) ram[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ready <= '0;
    end else begin
      for (int w = 0; w < WR_PORTS; w++) begin
        if (wr_wen[w]) ready[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b1;
      end
      if (rdyI_wen) ready[rdyI_addr] <= rdyI_ready;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  hit;

    assign hit = ready[addr_q];

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        addr_q <= '0;
      end else if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rd_clkEn[p]) begin
              addr_q <= rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
              state  <= BUSY;
            end
          end
          BUSY: begin
            if (hit) begin
              if (rd_clkEn[p]) addr_q <= rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
              else             state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = ram[addr_q];
    assign rd_valid[p] = (state == BUSY) &&  hit;
    assign rd_wait[p]  = (state == BUSY) && !hit;
  end

endmodule
